butterfly_s2p_bm_dec: RTL and testbench

Receive-side counterpart of the butterfly_p2s / bm_renorm path. It collects num_output block-minifloat codes, arriving serially one lane per beat or as one parallel vector in bypass mode. It then decodes each code to saturated signed fixed point, applying the block's shared exponent shift, and presents one data_width vector per block. It sits between the serial link / systolic output and downstream fixed-point consumers.

---
 rtl/bm_pkg.sv | 27 ++
 rtl/bm_dec_lane.sv | 58 +++++
 rtl/butterfly_s2p_bm_dec.sv | 117 +++++++++++
 tb/tb_butterfly_s2p_bm_dec.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bm_pkg.sv
// Shared constants and code-field helpers for the block-minifloat decode path.
package bm_pkg;

  localparam int unsigned EBIT_DEF = 2;
  localparam int unsigned MBIT_DEF = 1;
  localparam int unsigned BIAS_DEF = 1;
  localparam int unsigned BM_W_DEF = 1 + EBIT_DEF + MBIT_DEF;

  // Widest raw magnitude: {1,m} shifted by the largest normal exponent step.
  localparam int unsigned RAW_W = MBIT_DEF + 1 + (2 ** EBIT_DEF - 2);

  localparam int unsigned SHIFT_W = 8;

  function automatic int unsigned raw_width(int unsigned ebit, int unsigned mbit);
    return mbit + 1 + (2 ** ebit - 2);
  endfunction

  // Code layout is {sign, exponent, mantissa}, mantissa at the LSBs.
  function automatic int unsigned sign_pos(int unsigned ebit, int unsigned mbit);
    return ebit + mbit;
  endfunction

  function automatic int unsigned exp_lsb(int unsigned mbit);
    return mbit;
  endfunction

endpackage

// File: rtl/bm_dec_lane.sv
// Combinational decode of one block-minifloat code into saturated signed fixed point.
module bm_dec_lane
  import bm_pkg::*;
#(
  parameter int unsigned data_width = 16,
  parameter int unsigned bm_width   = BM_W_DEF,
  parameter int unsigned EBIT       = EBIT_DEF,
  parameter int unsigned MBIT       = MBIT_DEF
) (
  input  logic [bm_width-1:0]   code,
  input  logic [SHIFT_W-1:0]    shift,
  output logic [data_width-1:0] dat
);

  localparam int unsigned RW       = raw_width(EBIT, MBIT);
  localparam int unsigned WW       = RW + data_width;
  localparam int unsigned SIGN_POS = sign_pos(EBIT, MBIT);
  localparam int unsigned EXP_LSB  = exp_lsb(MBIT);
  localparam logic [data_width-1:0] MAX_MAG = {1'b0, {(data_width - 1){1'b1}}};

  logic                  sgn;
  logic [EBIT-1:0]       e;
  logic [MBIT-1:0]       m;
  logic [MBIT:0]         mag;
  logic [EBIT-1:0]       sh;
  logic [RW-1:0]         raw;
  logic [WW-1:0]         wide;
  logic [SHIFT_W-1:0]    neg_amt;
  logic                  over;
  logic [data_width-1:0] clamped;

  assign sgn = code[SIGN_POS];
  assign e   = code[EXP_LSB +: EBIT];
  assign m   = code[MBIT-1:0];

  always_comb begin
    mag     = {(e != '0), m};
    sh      = (e != '0) ? e - EBIT'(1) : '0;
    raw     = RW'(mag) << sh;
    neg_amt = ~shift + SHIFT_W'(1);
    over    = 1'b0;
    wide    = '0;
    if (!shift[SHIFT_W-1]) begin
      // Any non-zero value shifted by data_width or more cannot fit.
      if (32'(shift) >= data_width) begin
        over = (raw != '0);
      end else begin
        wide = WW'(raw) << shift;
      end
    end else begin
      wide = WW'(raw) >> neg_amt;
    end
    over    = over || (wide > WW'(MAX_MAG));
    clamped = over ? MAX_MAG : wide[data_width-1:0];
    dat     = sgn ? (~clamped + data_width'(1)) : clamped;
  end

endmodule

// File: rtl/butterfly_s2p_bm_dec.sv
// Collects a block of minifloat codes (serial or parallel) and emits it decoded to fixed point.
module butterfly_s2p_bm_dec
  import bm_pkg::*;
#(
  parameter int unsigned data_width = 16,
  parameter int unsigned num_output = 8,
  parameter int unsigned bm_width   = BM_W_DEF,
  parameter int unsigned EBIT       = EBIT_DEF,
  parameter int unsigned MBIT       = MBIT_DEF,
  parameter int unsigned BIAS       = BIAS_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             by_pass,
  input  logic [SHIFT_W-1:0]               exp_shift,
  input  logic [bm_width-1:0]              up_serial_dat,
  input  logic                             up_serial_vld,
  output logic                             up_serial_rdy,
  input  logic [num_output*bm_width-1:0]   up_parallel_dat,
  input  logic                             up_parallel_vld,
  output logic                             up_parallel_rdy,
  output logic [num_output*data_width-1:0] dn_dat,
  output logic                             dn_vld,
  input  logic                             dn_rdy
);

  localparam int unsigned CNT_W = (num_output > 1) ? $clog2(num_output) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(num_output - 1);

  if (bm_width != 1 + EBIT + MBIT || BIAS >= 2 ** EBIT) begin : g_cfg_err
    $error("bm_width must equal 1+EBIT+MBIT and BIAS must lie inside the exponent range");
  end

  logic [CNT_W-1:0]                 cnt_q;
  logic                             col_full_q;
  logic [SHIFT_W-1:0]               shift_q;
  logic [num_output*bm_width-1:0]   collect_q;
  logic                             dn_vld_q;
  logic [num_output*data_width-1:0] dn_dat_q;

  logic                             out_free;
  logic                             ser_acc;
  logic                             par_acc;
  logic                             ser_emit;
  logic [num_output*bm_width-1:0]   dec_in;
  logic [SHIFT_W-1:0]               dec_shift;
  logic [num_output*data_width-1:0] dec_out;

  assign out_free        = !dn_vld_q || dn_rdy;
  assign up_serial_rdy   = !by_pass && (!col_full_q || out_free);
  assign up_parallel_rdy = by_pass && out_free;
  assign ser_acc         = up_serial_vld && up_serial_rdy;
  assign par_acc         = up_parallel_vld && up_parallel_rdy;
  assign ser_emit        = !by_pass && col_full_q && out_free;

  // One decoder bank serves both paths; by_pass only flips while idle.
  assign dec_in    = by_pass ? up_parallel_dat : collect_q;
  assign dec_shift = by_pass ? exp_shift : shift_q;

  for (genvar k = 0; k < num_output; k++) begin : g_lane
    bm_dec_lane #(
      .data_width(data_width),
      .bm_width  (bm_width),
      .EBIT      (EBIT),
      .MBIT      (MBIT)
    ) u_lane (
      .code (dec_in[k*bm_width +: bm_width]),
      .shift(dec_shift),
      .dat  (dec_out[k*data_width +: data_width])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      col_full_q <= 1'b0;
      shift_q    <= '0;
      collect_q  <= '0;
    end else begin
      if (ser_emit) begin
        col_full_q <= 1'b0;
      end
      if (ser_acc) begin
        for (int k = 0; k < num_output; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            collect_q[k*bm_width +: bm_width] <= up_serial_dat;
          end
        end
        if (cnt_q == '0) begin
          shift_q <= exp_shift;
        end
        if (cnt_q == LAST_LANE) begin
          cnt_q      <= '0;
          col_full_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_vld_q <= 1'b0;
      dn_dat_q <= '0;
    end else if (ser_emit || par_acc) begin
      dn_vld_q <= 1'b1;
      dn_dat_q <= dec_out;
    end else if (dn_rdy) begin
      dn_vld_q <= 1'b0;
    end
  end

  assign dn_vld = dn_vld_q;
  assign dn_dat = dn_dat_q;

endmodule

// File: tb/tb_butterfly_s2p_bm_dec.sv
// Self-checking bench for butterfly_s2p_bm_dec: vector table, corner sequences, random blocks.
module tb_butterfly_s2p_bm_dec;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         by_pass;
  logic [7:0]   exp_shift;
  logic [3:0]   up_serial_dat;
  logic         up_serial_vld;
  logic         up_serial_rdy;
  logic [31:0]  up_parallel_dat;
  logic         up_parallel_vld;
  logic         up_parallel_rdy;
  logic [127:0] dn_dat;
  logic         dn_vld;
  logic         dn_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string        name;
    logic [31:0]  codes;
    logic [7:0]   sh;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  butterfly_s2p_bm_dec dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .by_pass        (by_pass),
    .exp_shift      (exp_shift),
    .up_serial_dat  (up_serial_dat),
    .up_serial_vld  (up_serial_vld),
    .up_serial_rdy  (up_serial_rdy),
    .up_parallel_dat(up_parallel_dat),
    .up_parallel_vld(up_parallel_vld),
    .up_parallel_rdy(up_parallel_rdy),
    .dn_dat         (dn_dat),
    .dn_vld         (dn_vld),
    .dn_rdy         (dn_rdy)
  );

  // Value of a code in units of 2^(1-BIAS-MBIT), scaled by 2^shift, clamped, signed.
  function automatic logic [15:0] model_lane(input logic [3:0] code, input logic [7:0] sh);
    longint v;
    int     e;
    int     k;
    e = int'(code[2:1]);
    if (e == 0) v = longint'(code[0]);
    else v = longint'(2 + int'(code[0])) * (longint'(1) << (e - 1));
    k = int'($signed(sh));
    if (k >= 0) begin
      if (k >= 40) v = (v != 0) ? 64'd40000 : 64'd0;
      else v = v * (longint'(1) << k);
    end else begin
      if (-k >= 40) v = 0;
      else v = v / (longint'(1) << (-k));
    end
    if (v > 32767) v = 32767;
    if (code[3]) v = -v;
    return 16'(v);
  endfunction

  function automatic logic [127:0] model_block(input logic [31:0] codes, input logic [7:0] sh);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = model_lane(codes[k*4 +: 4], sh);
    return r;
  endfunction

  function automatic logic [127:0] rep16(input logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout required handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input logic [31:0] codes, input logic [7:0] sh, input int n);
    for (int k = 0; k < n; k++) begin
      int guard;
      guard         = 0;
      up_serial_vld = 1'b1;
      up_serial_dat = codes[k*4 +: 4];
      exp_shift     = (k == 0) ? sh : ~sh;
      #1;
      while (!up_serial_rdy && guard < 100) begin
        tick();
        #1;
        guard++;
      end
      if (guard >= 100) timeout_fail("serial_rdy_wait");
      tick();
    end
    up_serial_vld = 1'b0;
  endtask

  task automatic wait_dn(output bit ok);
    int g;
    g = 0;
    while (!dn_vld && g < 20) begin
      tick();
      g++;
    end
    ok = dn_vld;
    if (!ok) timeout_fail("dn_vld_wait");
  endtask

  task automatic run_random(input bit par, input int nblk);
    logic [127:0] exp_q[$];
    logic [31:0]  cur_codes;
    logic [7:0]   cur_sh;
    logic [127:0] held;
    logic [127:0] want;
    bit           stalled;
    int           beat, sent, got, cyc;
    beat = 0; sent = 0; got = 0; cyc = 0; stalled = 0; held = '0;
    cur_codes = $urandom;
    cur_sh    = 8'($urandom_range(0, 44)) - 8'd22;
    while (got < nblk && cyc < 4000) begin
      tick();
      cyc++;
      if (stalled) begin
        check("rand_hold_vld", 128'(dn_vld), 128'(1));
        check("rand_hold_dat", dn_dat, held);
      end
      dn_rdy = ($urandom_range(0, 3) != 0);
      if (par) begin
        up_parallel_vld = (sent < nblk) && ($urandom_range(0, 3) != 0);
        up_parallel_dat = cur_codes;
        exp_shift       = cur_sh;
      end else begin
        up_serial_vld = (sent < nblk) && ($urandom_range(0, 3) != 0);
        up_serial_dat = cur_codes[beat*4 +: 4];
        exp_shift     = (beat == 0) ? cur_sh : 8'($urandom);
      end
      #1;
      if (dn_vld && dn_rdy) begin
        if (exp_q.size() == 0) begin
          timeout_fail("rand_unexpected_output");
        end else begin
          want = exp_q.pop_front();
          check(par ? "rand_par_dat" : "rand_ser_dat", dn_dat, want);
        end
        got++;
      end
      stalled = dn_vld && !dn_rdy;
      held    = dn_dat;
      if (par ? (up_parallel_vld && up_parallel_rdy) : (up_serial_vld && up_serial_rdy)) begin
        if (!par) beat++;
        if (par || beat == 8) begin
          exp_q.push_back(model_block(cur_codes, cur_sh));
          beat      = 0;
          sent++;
          cur_codes = $urandom;
          cur_sh    = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                  : 8'($urandom_range(0, 44)) - 8'd22;
        end
      end
    end
    if (got < nblk) timeout_fail("rand_blocks");
    up_serial_vld   = 1'b0;
    up_parallel_vld = 1'b0;
    dn_rdy          = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    bit ok;
    int drops, nvld, first_rise, last_rise, accepts;
    logic [127:0] snap;

    rst_n = 1'b0; by_pass = 1'b0; exp_shift = '0; up_serial_dat = '0; up_serial_vld = 1'b0;
    up_parallel_dat = '0; up_parallel_vld = 1'b0; dn_rdy = 1'b0;

    vecs.push_back('{"all_0111_sh0", 32'h7777_7777, 8'd0, rep16(16'h000C)});
    vecs.push_back('{"mixed_lanes", 32'h7777_80A1, 8'd0,
                     {16'h000C, 16'h000C, 16'h000C, 16'h000C,
                      16'h0000, 16'h0000, 16'hFFFE, 16'h0001}});
    vecs.push_back('{"sat_pos13", 32'hF7F7_F7F7, 8'd13, {4{16'h8001, 16'h7FFF}}});
    vecs.push_back('{"shift_m3", 32'h7777_7777, 8'hFD, rep16(16'h0001)});
    vecs.push_back('{"shift_m8", 32'h7777_7777, 8'hF8, rep16(16'h0000)});
    vecs.push_back('{"shift_m128", 32'hFFFF_FFFF, 8'h80, rep16(16'h0000)});
    vecs.push_back('{"sub_sh2", 32'hB3B3_B3B3, 8'd2, {4{16'hFFF4, 16'h000C}}});
    vecs.push_back('{"zero_sh127", 32'h8080_8080, 8'd127, rep16(16'h0000)});
    vecs.push_back('{"norm_0101_sh1", 32'h5555_5555, 8'd1, rep16(16'h000C)});

    repeat (2) tick();
    check("reset_dn_vld", 128'(dn_vld), 128'(0));
    check("reset_dn_dat", dn_dat, '0);
    check("reset_ser_rdy", 128'(up_serial_rdy), 128'(1));
    check("reset_par_rdy", 128'(up_parallel_rdy), 128'(0));
    rst_n = 1'b1;
    tick();

    // Serial latency: dn_vld rises on the second edge after the last beat.
    dn_rdy = 1'b1;
    send_beats(32'h7777_7777, 8'd0, 8);
    check("t1_vld_edge1", 128'(dn_vld), 128'(0));
    tick();
    check("t1_vld_edge2", 128'(dn_vld), 128'(1));
    check("t1_dat", dn_dat, rep16(16'h000C));
    tick();
    check("t1_vld_consumed", 128'(dn_vld), 128'(0));

    foreach (vecs[i]) begin
      send_beats(vecs[i].codes, vecs[i].sh, 8);
      wait_dn(ok);
      if (ok) begin
        check({"ser_", vecs[i].name}, dn_dat, vecs[i].exp);
        check({"ser_model_", vecs[i].name}, dn_dat, model_block(vecs[i].codes, vecs[i].sh));
      end
      tick();
    end

    by_pass = 1'b1;
    tick();
    foreach (vecs[i]) begin
      up_parallel_vld = 1'b1;
      up_parallel_dat = vecs[i].codes;
      exp_shift       = vecs[i].sh;
      #1;
      check({"par_rdy_", vecs[i].name}, 128'(up_parallel_rdy), 128'(1));
      check({"par_ser_rdy_", vecs[i].name}, 128'(up_serial_rdy), 128'(0));
      tick();
      up_parallel_vld = 1'b0;
      check({"par_vld_", vecs[i].name}, 128'(dn_vld), 128'(1));
      check({"par_", vecs[i].name}, dn_dat, vecs[i].exp);
      tick();
    end
    by_pass = 1'b0;
    tick();
    check("ser_mode_par_rdy", 128'(up_parallel_rdy), 128'(0));

    // Back-to-back serial blocks with the consumer always ready.
    drops = 0; nvld = 0; first_rise = -1; last_rise = -1;
    for (int c = 0; c < 30; c++) begin
      up_serial_vld = (c < 24);
      up_serial_dat = 4'h7;
      exp_shift     = (c % 8 == 0) ? 8'd0 : 8'h55;
      #1;
      if (c < 24 && !up_serial_rdy) drops++;
      if (dn_vld) begin
        nvld++;
        if (first_rise < 0) first_rise = c;
        last_rise = c;
        check("t4_b2b_dat", dn_dat, rep16(16'h000C));
      end
      tick();
    end
    up_serial_vld = 1'b0;
    check("t4_rdy_drops", 128'(drops), 128'(0));
    check("t4_block_count", 128'(nvld), 128'(3));
    check("t4_first_rise", 128'(first_rise), 128'(9));
    check("t4_spacing", 128'(last_rise - first_rise), 128'(16));

    // Consumer stalled: one block held on dn, one in collect, then serial input stalls.
    dn_rdy = 1'b0; accepts = 0; snap = '0;
    for (int c = 0; c < 30; c++) begin
      up_serial_vld = 1'b1;
      up_serial_dat = (accepts < 8) ? 4'h7 : 4'h3;
      exp_shift     = (accepts % 8 == 0) ? 8'd0 : 8'hA5;
      #1;
      if (up_serial_vld && up_serial_rdy) accepts++;
      if (dn_vld && snap == '0) snap = dn_dat;
      else if (dn_vld) check("t4_stall_stable", dn_dat, snap);
      tick();
    end
    up_serial_vld = 1'b0;
    check("t4_stall_accepts", 128'(accepts), 128'(16));
    check("t4_stall_rdy", 128'(up_serial_rdy), 128'(0));
    check("t4_stall_dat", dn_dat, rep16(16'h000C));
    dn_rdy = 1'b1;
    tick();
    check("t4_release_vld", 128'(dn_vld), 128'(1));
    check("t4_release_dat", dn_dat, rep16(16'h0003));
    tick();
    check("t4_drained", 128'(dn_vld), 128'(0));

    run_random(1'b0, 25);
    by_pass = 1'b1;
    tick();
    run_random(1'b1, 25);
    by_pass = 1'b0;
    tick();

    // Reset mid-block drops both the pending output and the partial block.
    dn_rdy = 1'b0;
    send_beats(32'h7777_7777, 8'd0, 8);
    send_beats(32'hFFFF_FFFF, 8'd5, 3);
    tick();
    check("t6_pending_vld", 128'(dn_vld), 128'(1));
    rst_n = 1'b0;
    #1;
    check("t6_reset_vld", 128'(dn_vld), 128'(0));
    check("t6_reset_dat", dn_dat, '0);
    tick();
    rst_n  = 1'b1;
    dn_rdy = 1'b1;
    tick();
    send_beats(32'h3333_3333, 8'd0, 8);
    wait_dn(ok);
    if (ok) check("t6_fresh_block", dn_dat, rep16(16'h0003));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
